dtc_feature_packer: RTL and testbench
=====================================

// Module: dtc_feature_packer
// PURPOSE
//  Producer-side front end for the combinational decision-tree classifiers (12-bit inp -> 3-bit outp).
//  - Assembles a serial feature stream, one bit per accepted beat, into a 12-bit feature vector.
//  - Drives that vector, registered and stable, into a classifier instance.
//  - Captures the returned class and presents it downstream on a valid/ready handshake.
//  - Counts classified vectors.
// PARAMETERS
//  NFEAT    12  feature vector width; equals the classifier inp width
//  CLS_W    3   class width; equals the classifier outp width
//  CNT_W    16  width of the classified-vector counter
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      synchronous, active-high reset
//  feat_bit     in   1      serial feature bit, LSB (inp[0]) first
//  feat_valid   in   1      feat_bit valid
//  feat_ready   out  1      packer accepts feat_bit this cycle
//  vec_out      out  NFEAT  registered vector to classifier inp
//  class_in     in   CLS_W  classifier outp (combinational from vec_out)
//  class_out    out  CLS_W  captured class
//  class_valid  out  1      class_out valid
//  class_ready  in   1      downstream accepts class_out
//  vec_cnt      out  CNT_W  number of vectors whose class was accepted downstream
//  err          out  1      parity-error pulse (see CONFIGURATION)
// BEHAVIOUR
//  Reset values:
//  - state=COLLECT, bitcnt=0, shift reg=0.
//  - vec_out=0, class_out=0, class_valid=0, vec_cnt=0, err=0.
//  - feat_ready=1 in the first cycle after reset.
//  Beat rule: a beat is accepted when feat_valid && feat_ready.
//  COLLECT:
//  - feat_ready=1.
//  - Each accepted beat writes shreg[bitcnt]=feat_bit and increments bitcnt.
//  - Beat with bitcnt==NFEAT-1: vec_out<=assembled vector (incl. this bit), bitcnt<=0, next=EVAL.
//  - feat_valid low: hold; no timeout.
//  EVAL (exactly 1 cycle):
//  - feat_ready=0; vec_out stable.
//  - class_out<=class_in, class_valid<=1, next=PRESENT.
//  PRESENT:
//  - feat_ready=0; class_valid=1; class_out and vec_out held stable.
//  - On class_ready: class_valid<=0, vec_cnt<=vec_cnt+1 (wraps at 2^CNT_W-1 -> 0), next=COLLECT.
//  - No beat is accepted in the same cycle as class_ready.
//  Latency:
//  - Last bit accepted at cycle t -> vec_out updated at t+1, class_valid high at t+2.
//  - With class_ready held high, next feat_ready=1 at t+3.
//  vec_out changes only on COLLECT->EVAL; it holds the last vector while the next one is collected.
//  Reset mid-operation (any state): partial vector discarded, bitcnt=0, pending class dropped, all outputs to reset values.
//  feat_valid during EVAL/PRESENT is ignored; the bit is not consumed (upstream holds it).
// CONFIGURATION
//  Macro DTC_PARITY_EN:
//  - Defined:
//    - After NFEAT data bits, state PARITY (feat_ready=1) accepts one more beat carrying even parity over the 12 bits.
//    - Match: vec_out<=vector, next=EVAL.
//    - Mismatch: err=1 for exactly one cycle, vector dropped, vec_out unchanged, vec_cnt unchanged, next=COLLECT.
//    - Latency from parity beat equals the no-parity latency from the last bit.
//  - Undefined: no PARITY state; err tied 0; every 12th beat goes straight to EVAL.
// TESTING
//  Bench classifier model: returns 3'b110 for 12'hA5C, 3'b001 for 12'h000, 3'b011 otherwise.
//  1. Reset, stream 12'hA5C LSB-first at 1 beat/cycle, class_ready=1
//     -> vec_out=12'hA5C one cycle after the 12th beat; class_valid=1 with class_out=3'b110 one cycle later for 1 cycle; vec_cnt=1.
//  2. As 1 with class_ready=0 for 5 cycles
//     -> class_valid, class_out, vec_out held; feat_ready=0 throughout; vec_cnt increments only on the ready cycle.
//  3. Random feat_valid gaps (50%) over 3 vectors 12'h000, 12'hFFF, 12'hA5C
//     -> classes 001, 011, 110 in order; vec_cnt=3.
//  4. Assert rst after 7 beats, then stream 12'h000
//     -> class_out=3'b001; no trace of the partial bits; vec_cnt=1.
//  5. Preload vec_cnt to 16'hFFFF via 65535 vectors (or force), classify one more -> vec_cnt=0.
//  6. DTC_PARITY_EN: 12'hA5C with parity 1 (bad; popcount is 6)
//     -> err pulses 1 cycle, no class_valid, vec_cnt unchanged; resend with parity 0 -> class_out=3'b110.

Source files
------------

// File: rtl/dtc_feature_packer.sv
// rtl/dtc_feature_packer.sv - serial feature packer and class capture for a decision-tree classifier (optional parity beat: DTC_PARITY_EN)
module dtc_feature_packer #(
   parameter int NFEAT = 12,
   parameter int CLS_W = 3,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             feat_bit,
   input  logic             feat_valid,
   output logic             feat_ready,
   output logic [NFEAT-1:0] vec_out,
   input  logic [CLS_W-1:0] class_in,
   output logic [CLS_W-1:0] class_out,
   output logic             class_valid,
   input  logic             class_ready,
   output logic [CNT_W-1:0] vec_cnt,
   output logic             err
);

   localparam int BC_W = $clog2(NFEAT);
   localparam logic [BC_W-1:0] LAST_BIT = BC_W'(NFEAT - 1);

`ifdef DTC_PARITY_EN
   typedef enum logic [1:0] {COLLECT, EVAL, PRESENT, PARITY} state_t;
`else
   typedef enum logic [1:0] {COLLECT, EVAL, PRESENT} state_t;
`endif

   state_t           state_q, state_d;
   logic [BC_W-1:0]  bitcnt_q, bitcnt_d;
   logic [NFEAT-1:0] shreg_q, shreg_d;
   logic [NFEAT-1:0] vec_q, vec_d;
   logic [CLS_W-1:0] class_q, class_d;
   logic             cvalid_q, cvalid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   // State register and datapath registers; reset discards any partial vector or pending class
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= COLLECT;
         bitcnt_q <= '0;
         shreg_q  <= '0;
         vec_q    <= '0;
         class_q  <= '0;
         cvalid_q <= 1'b0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         bitcnt_q <= bitcnt_d;
         shreg_q  <= shreg_d;
         vec_q    <= vec_d;
         class_q  <= class_d;
         cvalid_q <= cvalid_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
      end
   end

   // Next-state and handshake logic; vec_out only moves when a complete (and checked) vector is handed off
   always_comb begin
      state_d    = state_q;
      bitcnt_d   = bitcnt_q;
      shreg_d    = shreg_q;
      vec_d      = vec_q;
      class_d    = class_q;
      cvalid_d   = cvalid_q;
      cnt_d      = cnt_q;
      err_d      = 1'b0;
      feat_ready = 1'b0;
      case (state_q)
         COLLECT: begin
            feat_ready = 1'b1;
            if (feat_valid) begin
               shreg_d[bitcnt_q] = feat_bit;
               if (bitcnt_q == LAST_BIT) begin
                  bitcnt_d = '0;
`ifdef DTC_PARITY_EN
                  state_d  = PARITY;
`else
                  vec_d    = shreg_d;
                  state_d  = EVAL;
`endif
               end else begin
                  bitcnt_d = bitcnt_q + BC_W'(1);
               end
            end
         end
`ifdef DTC_PARITY_EN
         PARITY: begin
            feat_ready = 1'b1;
            if (feat_valid) begin
               // Even parity: the parity bit equals the XOR of the data bits
               if (feat_bit == ^shreg_q) begin
                  vec_d   = shreg_q;
                  state_d = EVAL;
               end else begin
                  err_d   = 1'b1;
                  state_d = COLLECT;
               end
            end
         end
`endif
         EVAL: begin
            class_d  = class_in;
            cvalid_d = 1'b1;
            state_d  = PRESENT;
         end
         PRESENT: begin
            if (class_ready) begin
               cvalid_d = 1'b0;
               cnt_d    = cnt_q + CNT_W'(1);
               state_d  = COLLECT;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   assign vec_out     = vec_q;
   assign class_out   = class_q;
   assign class_valid = cvalid_q;
   assign vec_cnt     = cnt_q;
   assign err         = err_q;

endmodule

// File: tb/tb_dtc_feature_packer.sv
// tb/tb_dtc_feature_packer.sv - directed table-driven bench for dtc_feature_packer
module tb_dtc_feature_packer;
   localparam int NFEAT = 12;
   localparam int CLS_W = 3;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             feat_bit;
   logic             feat_valid;
   logic             feat_ready;
   logic [NFEAT-1:0] vec_out;
   logic [CLS_W-1:0] class_in;
   logic [CLS_W-1:0] class_out;
   logic             class_valid;
   logic             class_ready;
   logic [CNT_W-1:0] vec_cnt;
   logic             err;

   dtc_feature_packer #(.NFEAT(NFEAT), .CLS_W(CLS_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .feat_bit(feat_bit), .feat_valid(feat_valid),
      .feat_ready(feat_ready), .vec_out(vec_out), .class_in(class_in),
      .class_out(class_out), .class_valid(class_valid), .class_ready(class_ready),
      .vec_cnt(vec_cnt), .err(err)
   );

   always #5 clk = ~clk;

   // Classifier model
   assign class_in = (vec_out == 12'hA5C) ? 3'b110 :
                     (vec_out == 12'h000) ? 3'b001 : 3'b011;

   int n_cmp = 0;
   int n_bad = 0;
   int exp_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Streams nbits of v LSB first (plus a parity beat when enabled and the vector is complete).
   // Returns 1ns after the posedge that accepted the last beat.
   task automatic send_vec(input logic [11:0] v, input bit gaps, input int nbits, input bit par_flip);
      int total;
      int b;
      int guard;
      logic bv;
      total = nbits;
`ifdef DTC_PARITY_EN
      if (nbits == NFEAT) total = NFEAT + 1;
`endif
      b = 0;
      while (b < total) begin
         @(negedge clk);
         if (gaps && $urandom_range(0, 1) == 0) begin
            feat_valid = 1'b0;
            continue;
         end
         bv = (b < NFEAT) ? v[b] : ((^v) ^ par_flip);
         feat_bit   = bv;
         feat_valid = 1'b1;
         guard = 0;
         while (!feat_ready && guard < 40) begin
            @(negedge clk);
            guard++;
         end
         if (!feat_ready) begin
            check("beat_accept_timeout", {31'd0, feat_ready}, 32'd1);
            feat_valid = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
         b++;
      end
      feat_valid = 1'b0;
   endtask

   typedef struct {
      logic [11:0] vec;
      bit          gaps;
      int          stall;
      logic [2:0]  cls;
   } vec_t;

   vec_t tbl[6];

   initial begin
      tbl[0] = '{vec: 12'h000, gaps: 1'b1, stall: 0, cls: 3'b001};
      tbl[1] = '{vec: 12'hFFF, gaps: 1'b1, stall: 0, cls: 3'b011};
      tbl[2] = '{vec: 12'hA5C, gaps: 1'b1, stall: 0, cls: 3'b110};
      tbl[3] = '{vec: 12'hA5C, gaps: 1'b0, stall: 5, cls: 3'b110};
      tbl[4] = '{vec: 12'h123, gaps: 1'b0, stall: 2, cls: 3'b011};
      tbl[5] = '{vec: 12'h800, gaps: 1'b1, stall: 1, cls: 3'b011};

      rst = 1'b1; feat_bit = 1'b0; feat_valid = 1'b0; class_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_vec_out", vec_out, 0);
      check("rst_class_out", class_out, 0);
      check("rst_class_valid", class_valid, 0);
      check("rst_vec_cnt", vec_cnt, 0);
      check("rst_err", err, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_feat_ready", feat_ready, 1);

      // Back-to-back stream, ready held high: exact latency
      class_ready = 1'b1;
      send_vec(12'hA5C, 1'b0, NFEAT, 1'b0);
      check("t1_vec_out", vec_out, 12'hA5C);
      check("t1_valid_early", class_valid, 0);
      check("t1_ready_eval", feat_ready, 0);
      @(posedge clk); #1;
      check("t1_class_valid", class_valid, 1);
      check("t1_class_out", class_out, 3'b110);
      @(posedge clk); #1;
      exp_cnt++;
      check("t1_valid_drop", class_valid, 0);
      check("t1_feat_ready", feat_ready, 1);
      check("t1_vec_cnt", vec_cnt, exp_cnt);

      // Table: gaps, stalls with upstream pushing during PRESENT
      for (int i = 0; i < 6; i++) begin
         class_ready = (tbl[i].stall == 0);
         send_vec(tbl[i].vec, tbl[i].gaps, NFEAT, 1'b0);
         check($sformatf("tbl%0d_vec_out", i), vec_out, tbl[i].vec);
         @(posedge clk); #1;
         check($sformatf("tbl%0d_class_valid", i), class_valid, 1);
         check($sformatf("tbl%0d_class_out", i), class_out, tbl[i].cls);
         for (int s = 0; s < tbl[i].stall; s++) begin
            @(negedge clk);
            feat_valid = 1'b1;
            feat_bit   = 1'b1;
            @(posedge clk); #1;
            check($sformatf("tbl%0d_stall%0d_valid", i, s), class_valid, 1);
            check($sformatf("tbl%0d_stall%0d_class", i, s), class_out, tbl[i].cls);
            check($sformatf("tbl%0d_stall%0d_vec", i, s), vec_out, tbl[i].vec);
            check($sformatf("tbl%0d_stall%0d_fready", i, s), feat_ready, 0);
            check($sformatf("tbl%0d_stall%0d_cnt", i, s), vec_cnt, exp_cnt);
         end
         if (tbl[i].stall != 0) begin
            @(negedge clk);
            feat_valid  = 1'b0;
            class_ready = 1'b1;
         end
         @(posedge clk); #1;
         exp_cnt++;
         check($sformatf("tbl%0d_valid_drop", i), class_valid, 0);
         check($sformatf("tbl%0d_vec_cnt", i), vec_cnt, exp_cnt);
         check($sformatf("tbl%0d_fready", i), feat_ready, 1);
      end

      // Reset after a partial vector
      class_ready = 1'b1;
      send_vec(12'hFFF, 1'b0, 7, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      exp_cnt = 0;
      check("mid_rst_vec_out", vec_out, 0);
      check("mid_rst_vec_cnt", vec_cnt, 0);
      check("mid_rst_fready", feat_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      send_vec(12'h000, 1'b0, NFEAT, 1'b0);
      check("mid_rst_vec", vec_out, 12'h000);
      @(posedge clk); #1;
      check("mid_rst_class", class_out, 3'b001);
      @(posedge clk); #1;
      exp_cnt++;
      check("mid_rst_cnt", vec_cnt, exp_cnt);

      // Counter wrap
      @(negedge clk);
      force dut.cnt_q = 16'hFFFF;
      @(posedge clk);
      @(negedge clk);
      release dut.cnt_q;
      @(posedge clk); #1;
      check("wrap_preload", vec_cnt, 16'hFFFF);
      send_vec(12'h000, 1'b0, NFEAT, 1'b0);
      @(posedge clk); #1;
      check("wrap_class", class_out, 3'b001);
      @(posedge clk); #1;
      exp_cnt = 0;
      check("wrap_cnt", vec_cnt, exp_cnt);

`ifdef DTC_PARITY_EN
      // Bad parity drops the vector, good parity resend goes through
      send_vec(12'hA5C, 1'b0, NFEAT, 1'b1);
      check("par_err_pulse", err, 1);
      check("par_vec_held", vec_out, 12'h000);
      check("par_fready", feat_ready, 1);
      @(posedge clk); #1;
      check("par_err_clear", err, 0);
      check("par_no_valid", class_valid, 0);
      check("par_cnt_held", vec_cnt, exp_cnt);
      send_vec(12'hA5C, 1'b0, NFEAT, 1'b0);
      check("par_ok_vec", vec_out, 12'hA5C);
      check("par_ok_err", err, 0);
      @(posedge clk); #1;
      check("par_ok_valid", class_valid, 1);
      check("par_ok_class", class_out, 3'b110);
      @(posedge clk); #1;
      exp_cnt++;
      check("par_ok_cnt", vec_cnt, exp_cnt);
`else
      check("noparity_err", err, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Overall time bound
   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish in time");
      $fatal(1);
   end
endmodule
